hack_mem_arbiter: RTL
=====================

Name: hack_mem_arbiter

Overview:
Two-port arbiter in front of the single-port Hack Memory (RAM16K 0x0000-0x3FFF, Screen 0x4000-0x5FFF, keyboard 0x6000). It shares the memory between the CPU data port and a video scan-out reader that fetches screen words. It also enforces keyboard-region write protection. It sits between the CPU/video blocks and the Memory instance and drives that instance's load/address/in ports.

Parameters:
ADDR_W, 15, memory address width
DATA_W, 16, data word width
SCREEN_BASE, 15'h4000, base address added to video word offset
KBD_ADDR, 15'h6000, keyboard register address; addresses >= this are write-protected
STARVE_MAX, 4, consecutive denied video cycles before video is forced to win (1..15)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  grant/accept strobe, combinational, same cycle as grant
cpu_rdata  out  DATA_W  registered read data
cpu_rvalid  out  1  cpu_rdata valid, cycle after a read ack
vid_req  in  1  video read request, held until vid_ack
vid_addr  in  13  screen word offset 0..8191
vid_ack  out  1  grant strobe, combinational
vid_rdata  out  DATA_W  registered read data
vid_rvalid  out  1  vid_rdata valid, cycle after vid_ack
mem_load  out  1  to Memory load
mem_address  out  ADDR_W  to Memory address
mem_in  out  DATA_W  to Memory in
mem_out  in  DATA_W  from Memory out (combinational read)
cnt_cpu  out  16  CPU grant count (ARB_PERF_EN)
cnt_vid  out  16  video grant count (ARB_PERF_EN)
cnt_conflict  out  16  cycles with both requests (ARB_PERF_EN)

Behaviour:
- Reset: clk and rst_n are the clock and reset; reset is synchronous and active-low. While rst_n=0, all acks, rvalids, mem_load, mem_address and mem_in are forced to 0. Registered rdata, starve_cnt and counters clear to 0 on the edge. No write reaches memory during reset. After reset is released, granting starts in the first cycle with rst_n=1.
- Per-cycle grant, at most one grantee per cycle:
  - vid wins if vid_req=1 and (cpu_req=0 or starve_cnt==STARVE_MAX).
  - Otherwise cpu wins if cpu_req=1.
  - Otherwise idle.
- Grant state, named by the 2-bit grant register: IDLE, G_CPU, G_VID. It is registered as last_grant and drives rvalid routing the next cycle.
- CPU grant:
  - mem_address=cpu_addr, mem_in=cpu_wdata, cpu_ack=1.
  - mem_load=cpu_we & (cpu_addr < KBD_ADDR). Writes at or above KBD_ADDR are acked but dropped.
  - On a read, mem_out is captured into cpu_rdata at the edge, and cpu_rvalid=1 the next cycle for one cycle.
  - A read with cpu_addr > KBD_ADDR returns 0. A read of KBD_ADDR returns mem_out (keyboard).
- Video grant:
  - mem_address=SCREEN_BASE+vid_addr, mem_load=0, vid_ack=1.
  - vid_rdata captured at the edge; vid_rvalid=1 the next cycle.
- Idle: mem_address=0, mem_in=0, mem_load=0.
- Back-to-back: a requester whose req stays high after ack is a new request. It is eligible the very next cycle, giving a throughput of 1/cycle.
- starve_cnt (4 bits):
  - Increments, saturating at STARVE_MAX, each cycle vid_req=1 and vid is not granted.
  - Clears on a vid grant or when vid_req=0.
- Simultaneous requests with starve_cnt<STARVE_MAX: CPU granted, video waits.
- Request dropped before ack: no access, no rvalid. Requesters must not do this, but the arbiter tolerates it.
- Reset mid-burst: a pending rvalid in the reset cycle is suppressed. The starvation history is lost.

Optional Feature:
ARB_PERF_EN:
- Defined: cnt_cpu/cnt_vid increment per respective grant and cnt_conflict per cycle with cpu_req&vid_req. Counters are 16-bit wrap-around and clear on reset.
- Undefined: no counter flops; the three outputs are tied to 0.

Decomposition:
- Shared package hack_mem_pkg: address map constants (RAM_TOP 15'h3FFF, SCREEN_BASE, KBD_ADDR), the grant enum (IDLE/G_CPU/G_VID), and the DATA_W/ADDR_W defaults. The same package is reusable by the Memory block and the CPU.
- Optional sub-module hack_mem_perf holding the three counters; it is instantiated only under ARB_PERF_EN.
- The arbitration and datapath muxing stay in the top module.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with cpu_req=1, cpu_we=1, cpu_addr=0, cpu_wdata=16'hFFFF -> mem_load=0, cpu_ack=0 throughout; a later read of addr 0 returns 0.
2. CPU write then read: write 16'hFFFF to 0x0000, then read 0x0000 -> cpu_ack in each grant cycle; cpu_rvalid=1 one cycle after the read ack with cpu_rdata=16'hFFFF.
3. Video fetch: CPU writes 16'd2222 to 0x4000, then vid_req with vid_addr=0 -> mem_address=0x4000, vid_ack=1; next cycle vid_rvalid=1, vid_rdata=16'd2222.
4. Contention with STARVE_MAX=4, both requests held high 20 cycles -> grant pattern CPU×4 then VID repeating; starve_cnt never exceeds 4.
5. Keyboard protect: cpu write 0x6000 data 16'h1234 with kbIn=16'h0041 -> cpu_ack=1, mem_load=0; a subsequent read of 0x6000 returns 16'h0041. A read of 0x6001 returns 0.
6. With ARB_PERF_EN, scenario 4 for 20 cycles -> cnt_cpu=16, cnt_vid=4, cnt_conflict=20. Without the macro, all three counters read 0.

Source files
------------

// File: rtl/hack_mem_pkg.sv
// Shared Hack Memory address map, bus widths and arbiter grant encoding.
// Reusable by the Memory block, the CPU and the memory arbiter.
package hack_mem_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    localparam logic [14:0] RAM_TOP     = 15'h3FFF;
    localparam logic [14:0] SCREEN_BASE = 15'h4000;
    localparam logic [14:0] KBD_ADDR    = 15'h6000;

    localparam int STARVE_MAX = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        G_CPU = 2'd1,
        G_VID = 2'd2
    } grant_e;

endpackage

// File: rtl/hack_mem_arbiter_if.sv
// Requester-side bus of the Hack memory arbiter: CPU data port and video reader.
// Handshake: req is held until the same-cycle ack; rvalid/rdata follow a read ack by one cycle.
interface hack_mem_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              vid_req;
    logic [12:0]       vid_addr;
    logic              vid_ack;
    logic [DATA_W-1:0] vid_rdata;
    logic              vid_rvalid;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_rvalid,
        output vid_req, vid_addr,
        input  vid_ack, vid_rdata, vid_rvalid
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_rvalid,
        input  vid_req, vid_addr,
        output vid_ack, vid_rdata, vid_rvalid
    );
endinterface

// File: rtl/hack_mem_perf.sv
// Grant and conflict counters for the memory arbiter; 16-bit, wrap-around,
// cleared by synchronous active-low reset.
module hack_mem_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_grant,
    input  logic        vid_grant,
    input  logic        conflict,
    output logic [15:0] cnt_cpu,
    output logic [15:0] cnt_vid,
    output logic [15:0] cnt_conflict
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_cpu      <= 16'd0;
            cnt_vid      <= 16'd0;
            cnt_conflict <= 16'd0;
        end else begin
            if (cpu_grant) cnt_cpu      <= cnt_cpu + 16'd1;
            if (vid_grant) cnt_vid      <= cnt_vid + 16'd1;
            if (conflict)  cnt_conflict <= cnt_conflict + 16'd1;
        end
    end

endmodule

// File: rtl/hack_mem_arbiter.sv
// Single-port Hack Memory arbiter between CPU and video scan-out, with keyboard write protect.
// Optional grant/conflict counters are built when ARB_PERF_EN is defined.
module hack_mem_arbiter #(
    parameter int                 ADDR_W      = hack_mem_pkg::ADDR_W,
    parameter int                 DATA_W      = hack_mem_pkg::DATA_W,
    parameter logic [ADDR_W-1:0]  SCREEN_BASE = hack_mem_pkg::SCREEN_BASE,
    parameter logic [ADDR_W-1:0]  KBD_ADDR    = hack_mem_pkg::KBD_ADDR,
    parameter int                 STARVE_MAX  = hack_mem_pkg::STARVE_MAX
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hack_mem_arbiter_if.slave    bus,
    output logic                 mem_load,
    output logic [ADDR_W-1:0]    mem_address,
    output logic [DATA_W-1:0]    mem_in,
    input  logic [DATA_W-1:0]    mem_out,
    output logic [15:0]          cnt_cpu,
    output logic [15:0]          cnt_vid,
    output logic [15:0]          cnt_conflict,
    output hack_mem_pkg::grant_e dbg_grant,
    output logic [3:0]           dbg_starve_cnt
);
    import hack_mem_pkg::*;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic              vid_win;
    logic              cpu_win;
    logic              cpu_rd;
    grant_e            grant;
    grant_e            last_grant;
    logic              last_cpu_rd;
    logic [3:0]        starve_cnt;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vid_rdata_q;

    // Grants are gated by rst_n so nothing is acked or written while in reset.
    always_comb begin
        vid_win = rst_n & bus.vid_req & (~bus.cpu_req | (starve_cnt == STARVE_LIM));
        cpu_win = rst_n & bus.cpu_req & ~vid_win;
        cpu_rd  = cpu_win & ~bus.cpu_we;
        if (vid_win)      grant = G_VID;
        else if (cpu_win) grant = G_CPU;
        else              grant = IDLE;
    end

    always_comb begin
        mem_load    = 1'b0;
        mem_address = '0;
        mem_in      = '0;
        case (grant)
            G_CPU: begin
                mem_address = bus.cpu_addr;
                mem_in      = bus.cpu_wdata;
                mem_load    = bus.cpu_we & (bus.cpu_addr < KBD_ADDR);
            end
            G_VID: mem_address = SCREEN_BASE + ADDR_W'(bus.vid_addr);
            default: ;
        endcase
    end

    assign bus.cpu_ack    = cpu_win;
    assign bus.vid_ack    = vid_win;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.vid_rdata  = vid_rdata_q;
    // The rst_n term suppresses an rvalid still pending from the cycle before reset.
    assign bus.cpu_rvalid = rst_n & (last_grant == G_CPU) & last_cpu_rd;
    assign bus.vid_rvalid = rst_n & (last_grant == G_VID);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant  <= IDLE;
            last_cpu_rd <= 1'b0;
            starve_cnt  <= 4'd0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            last_grant  <= grant;
            last_cpu_rd <= cpu_rd;
            // Reads beyond the keyboard register are unmapped and return 0.
            if (cpu_rd)
                cpu_rdata_q <= (bus.cpu_addr > KBD_ADDR) ? '0 : mem_out;
            if (vid_win)
                vid_rdata_q <= mem_out;
            if (!bus.vid_req || vid_win)
                starve_cnt <= 4'd0;
            else if (starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign dbg_grant      = last_grant;
    assign dbg_starve_cnt = starve_cnt;

`ifdef ARB_PERF_EN
    hack_mem_perf u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_grant    (cpu_win),
        .vid_grant    (vid_win),
        .conflict     (bus.cpu_req & bus.vid_req),
        .cnt_cpu      (cnt_cpu),
        .cnt_vid      (cnt_vid),
        .cnt_conflict (cnt_conflict)
    );
`else
    assign cnt_cpu      = 16'd0;
    assign cnt_vid      = 16'd0;
    assign cnt_conflict = 16'd0;
`endif

endmodule
